// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared CPU bus / sprite DMA types and register addresses
package nes_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_e;

  localparam logic [15:0] OAM_DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_DATA_REG = 16'h2004;

endpackage

// File: rtl/cpu_oam_dma_arbiter_if.sv
// rtl/cpu_oam_dma_arbiter_if.sv - CPU-side and memory-side bus signals of the OAM DMA arbiter
interface cpu_oam_dma_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ren;
  logic              cpu_wen;
  logic              cpu_rdy;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ren;
  logic              bus_wen;
  logic [DATA_W-1:0] bus_rdata;
  logic              dma_busy;

  modport master (
    output cpu_addr, cpu_wdata, cpu_ren, cpu_wen, bus_rdata,
    input  cpu_rdy, bus_addr, bus_wdata, bus_ren, bus_wen, dma_busy
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_ren, cpu_wen, bus_rdata,
    output cpu_rdy, bus_addr, bus_wdata, bus_ren, bus_wen, dma_busy
  );
endinterface

// File: rtl/cpu_oam_dma_arbiter.sv
// rtl/cpu_oam_dma_arbiter.sv - CPU bus pass-through with sprite DMA that halts the CPU and copies a page to OAM
module cpu_oam_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter logic [ADDR_W-1:0] DMA_REG_ADDR = OAM_DMA_REG,
  parameter logic [ADDR_W-1:0] DMA_DST_ADDR = OAM_DATA_REG,
  parameter int                XFER_LEN     = 256
) (
  input  logic                  clk,
  input  logic                  b_rst,
  cpu_oam_dma_arbiter_if.slave  io
);

  localparam int               IDX_W    = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

  dma_state_e        state;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        page;
  logic              cyc_par;
  logic              rdy_q;
  logic              busy_q;
  logic              trigger;
  logic [ADDR_W-1:0] src_addr;

  assign trigger  = io.cpu_wen && (io.cpu_addr == DMA_REG_ADDR);
  assign src_addr = {page, {(ADDR_W-8){1'b0}}} | ADDR_W'(idx);
  assign io.cpu_rdy  = rdy_q;
  assign io.dma_busy = busy_q;

  always_ff @(posedge clk) begin
    if (b_rst) begin
      state   <= IDLE;
      idx     <= '0;
      page    <= '0;
      cyc_par <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      cyc_par <= ~cyc_par;
      case (state)
        IDLE: begin
          if (trigger) begin
            page   <= io.cpu_wdata[7:0];
            state  <= HALT;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        // Skip ALIGN when the next cycle already has even parity, so reads land on cyc_par=0.
        HALT: begin
          if (!io.cpu_wen) state <= cyc_par ? READ : ALIGN;
        end
        ALIGN: begin
          if (cyc_par) state <= READ;
        end
        READ: state <= WRITE;
        WRITE: begin
          if (idx == IDX_LAST) begin
            idx    <= '0;
            state  <= IDLE;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= READ;
          end
        end
        default: begin
          state  <= IDLE;
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    io.bus_addr  = io.cpu_addr;
    io.bus_wdata = io.cpu_wdata;
    io.bus_ren   = 1'b0;
    io.bus_wen   = 1'b0;
    case (state)
      IDLE: begin
        io.bus_ren = io.cpu_ren;
        io.bus_wen = io.cpu_wen;
      end
      // The 6502 keeps writing through rdy, so those writes still have to reach memory.
      HALT: io.bus_wen = io.cpu_wen;
      READ: begin
        io.bus_addr = src_addr;
        io.bus_ren  = 1'b1;
      end
      WRITE: begin
        io.bus_addr  = DMA_DST_ADDR;
        io.bus_wdata = io.bus_rdata;
        io.bus_wen   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_oam_dma_arbiter.sv
// tb/tb_cpu_oam_dma_arbiter.sv - self-checking bench for cpu_oam_dma_arbiter
module tb_cpu_oam_dma_arbiter;

  localparam int LEN = 256;

  logic clk = 1'b0;
  logic b_rst = 1'b1;
  always #5 clk = ~clk;

  cpu_oam_dma_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bif ();

  cpu_oam_dma_arbiter dut (
    .clk   (clk),
    .b_rst (b_rst),
    .io    (bif)
  );

  logic [7:0] mem [0:65535];

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  // Abstract model: n counts cycles since reset, a DMA is a halt window then 2*LEN copy cycles from k0.
  int         n = 0;
  bit         m_busy = 1'b0;
  bit         m_halt = 1'b0;
  int         m_k0 = 0;
  logic [7:0] m_page = 8'h00;

  int          low_run = 0, last_low = 0;
  int          rd_cnt = 0, oam_cnt = 0, wen_cnt = 0, both_cnt = 0, bad_page = 0;
  logic [15:0] first_rd_addr = 16'h0000;
  int          first_rd_n = 0;

  always @(posedge clk) begin
    if (bif.bus_ren) bif.bus_rdata <= mem[bif.bus_addr];
    if (bif.bus_wen && bif.bus_addr != 16'h2004) mem[bif.bus_addr] <= bif.bus_wdata;
  end

  always @(negedge clk) begin
    logic        e_rdy, e_busy, e_ren, e_wen, a_care, d_care, ok;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    int          off;
    e_addr = 16'h0000; e_wd = 8'h00; a_care = 1'b0; d_care = 1'b0;
    if (!m_busy) begin
      e_rdy = 1'b1; e_busy = 1'b0;
      e_ren = bif.cpu_ren; e_wen = bif.cpu_wen;
      e_addr = bif.cpu_addr; e_wd = bif.cpu_wdata; a_care = 1'b1; d_care = 1'b1;
    end else begin
      e_rdy = 1'b0; e_busy = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
      if (m_halt) begin
        e_wen = bif.cpu_wen;
        if (bif.cpu_wen) begin
          e_addr = bif.cpu_addr; e_wd = bif.cpu_wdata; a_care = 1'b1; d_care = 1'b1;
        end
      end else if (n >= m_k0) begin
        off = n - m_k0;
        if (off % 2 == 0) begin
          e_ren = 1'b1; e_addr = {m_page, 8'(off / 2)}; a_care = 1'b1;
        end else begin
          e_wen = 1'b1; e_addr = 16'h2004; e_wd = mem[{m_page, 8'(off / 2)}];
          a_care = 1'b1; d_care = 1'b1;
        end
      end
    end

    if (chk_en) begin
      ok = (bif.cpu_rdy === e_rdy) && (bif.dma_busy === e_busy) &&
           (bif.bus_ren === e_ren) && (bif.bus_wen === e_wen) &&
           (!a_care || bif.bus_addr === e_addr) && (!d_care || bif.bus_wdata === e_wd);
      checks++;
      if (ok) passes++;
      else $display("FAIL cycle n=%0d act rdy=%b busy=%b ren=%b wen=%b addr=%h wd=%h exp rdy=%b busy=%b ren=%b wen=%b addr=%h wd=%h",
                    n, bif.cpu_rdy, bif.dma_busy, bif.bus_ren, bif.bus_wen, bif.bus_addr, bif.bus_wdata,
                    e_rdy, e_busy, e_ren, e_wen, e_addr, e_wd);

      if (bif.bus_ren && bif.bus_wen) both_cnt++;
      if (bif.bus_wen) wen_cnt++;
      if (bif.bus_wen && bif.bus_addr == 16'h2004) oam_cnt++;
      if (bif.dma_busy && bif.bus_ren) begin
        if (rd_cnt == 0) begin
          first_rd_addr = bif.bus_addr; first_rd_n = n;
        end else if (bif.bus_addr[15:8] != first_rd_addr[15:8]) bad_page++;
        rd_cnt++;
      end
      if (!bif.cpu_rdy) low_run++;
      else if (low_run != 0) begin
        last_low = low_run; low_run = 0;
      end
    end

    if (b_rst) begin
      m_busy = 1'b0; m_halt = 1'b0; n = 0;
    end else begin
      if (!m_busy) begin
        if (bif.cpu_wen && bif.cpu_addr == 16'h4014) begin
          m_busy = 1'b1; m_halt = 1'b1; m_page = bif.cpu_wdata;
        end
      end else if (m_halt) begin
        if (!bif.cpu_wen) begin
          m_halt = 1'b0;
          m_k0 = ((n + 1) % 2 == 0) ? n + 1 : n + 2;
        end
      end else if (n == m_k0 + 2 * LEN - 1) m_busy = 1'b0;
      n = n + 1;
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.cpu_ren = 1'b0; bif.cpu_wen = 1'b0; bif.cpu_addr = 16'h0000; bif.cpu_wdata = 8'h00;
  endtask

  task automatic align(input int par);
    while (n % 2 != par) step();
  endtask

  task automatic trig(input logic [7:0] pg);
    bif.cpu_ren = 1'b0; bif.cpu_wen = 1'b1; bif.cpu_addr = 16'h4014; bif.cpu_wdata = pg;
    step();
    idle();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      if (!bif.dma_busy) break;
      k++;
    end
    if (k >= 2000) lit("wait_idle_timeout", 32'd1, 32'd0);
    step();
  endtask

  int trig_n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 7) ^ ((i >> 8) * 29));
    idle();
    bif.bus_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    b_rst = 1'b0;
    chk_en = 1'b1;

    // 1: pass-through read after reset
    bif.cpu_addr = 16'h8000; bif.cpu_ren = 1'b1;
    #3;
    lit("t1_addr", 32'(bif.bus_addr), 32'h8000);
    lit("t1_ren", 32'(bif.bus_ren), 32'd1);
    lit("t1_rdy", 32'(bif.cpu_rdy), 32'd1);
    lit("t1_busy", 32'(bif.dma_busy), 32'd0);
    step();
    idle();
    repeat (3) step();

    // 2: trigger on even parity, then a back-to-back trigger on the IDLE re-entry cycle
    align(0);
    rd_cnt = 0; oam_cnt = 0;
    trig(8'h02);
    repeat (513) step();
    trig(8'h02);
    lit("t2_low", 32'(last_low), 32'd513);
    lit("t2_oam", 32'(oam_cnt), 32'd256);
    lit("t2_first", 32'(first_rd_addr), 32'h0200);
    rd_cnt = 0; oam_cnt = 0;
    repeat (514) step();
    lit("t2b_low", 32'(last_low), 32'd513);
    lit("t2b_oam", 32'(oam_cnt), 32'd256);

    // 3: trigger on odd parity costs one extra aligning cycle
    align(1);
    rd_cnt = 0;
    trig_n = n;
    trig(8'h02);
    wait_idle();
    lit("t3_low", 32'(last_low), 32'd514);
    lit("t3_lat", 32'(first_rd_n - trig_n), 32'd3);
    lit("t3_par", 32'(first_rd_n % 2), 32'd0);
    lit("t3_first", 32'(first_rd_addr), 32'h0200);

    // 4: two stack pushes right after the trigger
    align(0);
    oam_cnt = 0;
    bif.cpu_wen = 1'b1; bif.cpu_addr = 16'h4014; bif.cpu_wdata = 8'h02;
    step();
    bif.cpu_addr = 16'h01FD; bif.cpu_wdata = 8'hAA;
    step();
    bif.cpu_addr = 16'h01FC; bif.cpu_wdata = 8'hBB;
    step();
    idle();
    wait_idle();
    lit("t4_low", 32'(last_low), 32'd515);
    lit("t4_push0", 32'(mem[16'h01FD]), 32'hAA);
    lit("t4_push1", 32'(mem[16'h01FC]), 32'hBB);
    lit("t4_oam", 32'(oam_cnt), 32'd256);

    // 5: reset while reading byte 10, then a fresh DMA
    align(0);
    rd_cnt = 0;
    trig(8'h03);
    repeat (21) step();
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    wen_cnt = 0;
    #3;
    lit("t5_rdy", 32'(bif.cpu_rdy), 32'd1);
    lit("t5_busy", 32'(bif.dma_busy), 32'd0);
    repeat (20) step();
    lit("t5_nowen", 32'(wen_cnt), 32'd0);
    lit("t5_reads", 32'(rd_cnt), 32'd11);
    align(0);
    rd_cnt = 0; oam_cnt = 0;
    trig(8'h03);
    wait_idle();
    lit("t5_first", 32'(first_rd_addr), 32'h0300);
    lit("t5_oam", 32'(oam_cnt), 32'd256);

    // 6: trigger register write during a DMA is ignored
    align(0);
    rd_cnt = 0; bad_page = 0;
    trig(8'h02);
    repeat (50) step();
    bif.cpu_wen = 1'b1; bif.cpu_addr = 16'h4014; bif.cpu_wdata = 8'h07;
    step();
    idle();
    wait_idle();
    lit("t6_first", 32'(first_rd_addr), 32'h0200);
    lit("t6_page", 32'(bad_page), 32'd0);
    lit("t6_reads", 32'(rd_cnt), 32'd256);
    lit("t6_low", 32'(last_low), 32'd513);
    lit("t6_both", 32'(both_cnt), 32'd0);

    repeat (4) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
